mq_byte_sched: RTL and testbench
================================

# mq_byte_sched

Byte-emission scheduler for the MQ coder. It sits between the coder's byte-out path and the codestream sink. It holds the most recent byte so a late carry can be folded into it, tells the coder when the next byte must be bit-stuffed, forwards finished bytes over a valid/ready handshake, and runs the flush/termination sequence. It stalls the coder whenever the sink back-pressures.

## Interface
- No parameters.
- clk — in — 1 — single clock; all logic on posedge.
- rst — in — 1 — synchronous, active-low reset.
- byte_vld — in — 1 — coder presents a new byte.
- byte_in — in — 8 — byte value from the coder.
- carry_in — in — 1 — qualifies byte_vld; add 1 to the held byte before it is released.
- flush — in — 1 — terminate the codeword; sampled only when in_ready=1.
- in_ready — out — 1 — scheduler accepts byte_vld/flush this cycle.
- stuff — out — 1 — held byte equals 0xFF; the coder's next byte carries 7 bits.
- out_data — out — 8 — byte to the sink.
- out_valid — out — 1 — out_data valid.
- out_ready — in — 1 — sink accepts out_data.
- byte_cnt — out — 16 — bytes handed to the sink in the current codeword.
- done — out — 1 — one-cycle pulse at the end of termination.
- err — out — 1 — sticky protocol error; cleared only by reset.

## Operation
- Registers:
  - held[7:0] and held_v
  - output register out_data/out_valid
  - state ∈ {IDLE, RUN, FLUSH, DONE}
  - byte_cnt, err
- in_ready = (state ∈ {IDLE, RUN}) && (!out_valid || out_ready). It is 0 while rst=0.
- Accept means byte_vld && in_ready.
  - IDLE: byte_in → held, held_v=1, byte_cnt cleared to 0, go to RUN.
  - RUN:
    - next = carry_in ? held+1 (8-bit) : held.
    - next goes to the output register (out_valid=1).
    - byte_in → held.
  - carry_in while held=0xFF or held_v=0: carry dropped, err←1, otherwise processed normally.
- stuff = held_v && (held == 0xFF). It is combinational from the held register.
- Output handshake: out_valid && out_ready clears out_valid unless a new byte is loaded the same cycle, and increments byte_cnt (wraps 0xFFFF→0).
- Flush (flush && in_ready):
  - If byte_vld is also set, the byte is accepted first, then the flush applies to the new held byte.
  - RUN→FLUSH. IDLE→DONE (empty codeword, byte_cnt stays 0).
- FLUSH:
  - When the output register is free, held moves to the output (subject to Configuration) and held_v←0.
  - Then wait for out_valid=0, then go to DONE.
- DONE: done=1 for one cycle, then IDLE. byte_cnt holds its final value until the next accept in IDLE.
- Reset mid-operation: held, output register and state are discarded with no pending byte emitted. byte_cnt=0, err=0.

## Timing
- Reset values: in_ready=0, stuff=0, out_data=0x00, out_valid=0, byte_cnt=0, done=0, err=0, state=IDLE.
- Latency:
  - An accepted byte reaches out_valid at the cycle after the *next* accept (one-byte hold).
  - In FLUSH, held reaches out_valid at the cycle after the output register is free.
- done asserts the cycle after the last output handshake. From IDLE, done asserts the cycle after flush is accepted.
- out_data/out_valid are stable while out_valid && !out_ready.
- Throughput: one byte per cycle with out_ready held at 1.

## Configuration
- MQ_TRAIL_FF_DROP_EN defined:
  - At flush, a held byte of 0xFF is discarded (termination rule). It is not counted in byte_cnt.
  - FLUSH goes to DONE once the output register is empty.
- Undefined: the held byte is always emitted at flush, including 0xFF.

## Test plan
- Bytes 0x12, 0x34, 0x56, then flush, out_ready=1:
  - out sequence is 0x12, 0x34, 0x56.
  - done one cycle after the 0x56 handshake.
  - byte_cnt=3.
- Bytes 0x7F, then 0x00 with carry_in=1:
  - first output byte is 0x80.
  - err=0.
- Byte 0xFF:
  - stuff=1 while it is held.
  - next byte with carry_in=1 sets err=1 and emits 0xFF unmodified.
- Bytes 0xAA, 0xFF, then flush:
  - with MQ_TRAIL_FF_DROP_EN, outputs are 0xAA only and byte_cnt=1.
  - without it, outputs are 0xAA, 0xFF and byte_cnt=2.
- out_ready=0 for 5 cycles with the output register full:
  - in_ready=0.
  - out_data stable.
  - no byte lost after out_ready returns to 1.
- Flush in IDLE gives done on the next cycle with byte_cnt=0. Reset asserted in FLUSH gives all outputs at reset values next cycle.

Source files
------------

// File: rtl/mq_byte_sched.sv
// mq_byte_sched: byte-emission scheduler for the MQ coder.
// Holds the latest coder byte so a late carry can be folded in, flags bit
// stuffing after 0xFF, forwards finished bytes over valid/ready and runs the
// flush/termination sequence.
// Optional feature macro: MQ_TRAIL_FF_DROP_EN (drop a trailing 0xFF at flush).
module mq_byte_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  input  logic        carry_in,
  input  logic        flush,
  output logic        in_ready,
  output logic        stuff,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] byte_cnt,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  held_q, held_d;
  logic        heldV_q, heldV_d;
  logic [7:0]  outData_q, outData_d;
  logic        outValid_q, outValid_d;
  logic [15:0] byteCnt_q, byteCnt_d;
  logic        err_q, err_d;

  logic accept;
  logic handshake;
  logic outFree;
  logic flushAcc;
  logic carryBad;
  logic dropHeld;

  assign in_ready  = rst && ((state_q == IDLE) || (state_q == RUN)) &&
                     (!outValid_q || out_ready);
  assign accept    = byte_vld && in_ready;
  assign flushAcc  = flush && in_ready;
  assign handshake = outValid_q && out_ready;
  assign outFree   = !outValid_q || out_ready;
  assign carryBad  = carry_in && (!heldV_q || (held_q == 8'hFF));

`ifdef MQ_TRAIL_FF_DROP_EN
  assign dropHeld = (held_q == 8'hFF);
`else
  assign dropHeld = 1'b0;
`endif

  assign stuff     = heldV_q && (held_q == 8'hFF);
  assign out_data  = outData_q;
  assign out_valid = outValid_q;
  assign byte_cnt  = byteCnt_q;
  assign err       = err_q;
  assign done      = (state_q == DONE);

  // Next-state logic: sink handshake first, then per-state byte movement.
  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    heldV_d    = heldV_q;
    outData_d  = outData_q;
    outValid_d = outValid_q;
    byteCnt_d  = byteCnt_q;
    err_d      = err_q;

    if (handshake) begin
      outValid_d = 1'b0;
      byteCnt_d  = byteCnt_q + 16'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          held_d    = byte_in;
          heldV_d   = 1'b1;
          byteCnt_d = 16'd0;
          if (carryBad) err_d = 1'b1;
          state_d   = flush ? FLUSH : RUN;
        end else if (flushAcc) begin
          byteCnt_d = 16'd0;
          state_d   = DONE;
        end
      end
      RUN: begin
        if (accept) begin
          if (carryBad) err_d = 1'b1;
          outData_d  = held_q + {7'd0, carry_in && !carryBad};
          outValid_d = 1'b1;
          held_d     = byte_in;
          heldV_d    = 1'b1;
        end
        if (flushAcc) state_d = FLUSH;
      end
      FLUSH: begin
        if (heldV_q) begin
          if (dropHeld) begin
            heldV_d = 1'b0;
          end else if (outFree) begin
            outData_d  = held_q;
            outValid_d = 1'b1;
            heldV_d    = 1'b0;
          end
        end else if (outFree) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset discarding all pending bytes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      held_q     <= 8'h00;
      heldV_q    <= 1'b0;
      outData_q  <= 8'h00;
      outValid_q <= 1'b0;
      byteCnt_q  <= 16'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      heldV_q    <= heldV_d;
      outData_q  <= outData_d;
      outValid_q <= outValid_d;
      byteCnt_q  <= byteCnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mq_byte_sched.sv
// tb_mq_byte_sched: directed self-checking bench for mq_byte_sched.
// Honors MQ_TRAIL_FF_DROP_EN for the trailing-0xFF expectations.
module tb_mq_byte_sched;

  logic        clk;
  logic        rst;
  logic        byte_vld;
  logic [7:0]  byte_in;
  logic        carry_in;
  logic        flush;
  logic        in_ready;
  logic        stuff;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] byte_cnt;
  logic        done;
  logic        err;

  int compared;
  int mismatched;
  logic [7:0] outQ[$];

  mq_byte_sched dut (
    .clk(clk), .rst(rst), .byte_vld(byte_vld), .byte_in(byte_in),
    .carry_in(carry_in), .flush(flush), .in_ready(in_ready), .stuff(stuff),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .byte_cnt(byte_cnt), .done(done), .err(err)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every byte the sink accepts; sampled mid-cycle before the edge.
  always @(negedge clk) begin
    if (rst && out_valid && out_ready) outQ.push_back(out_data);
  end

  function automatic string qStr();
    string s;
    s = "";
    foreach (outQ[i]) s = {s, $sformatf("%02h ", outQ[i])};
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait (bounded) for in_ready, then clock it in.
  task automatic applyStimulus(input logic vld, input logic [7:0] b,
                               input logic c, input logic f);
    int waits;
    byte_vld = vld;
    byte_in  = b;
    carry_in = c;
    flush    = f;
    waits    = 0;
    #1;
    while (!in_ready && waits < 20) begin
      tick();
      waits++;
    end
    @(posedge clk);
    #1;
    byte_vld = 1'b0;
    carry_in = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    compared++;
    if ({in_ready, stuff, out_valid, done, err, out_data, byte_cnt} !== 29'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_values: got rdy=%b stuff=%b vld=%b done=%b err=%b data=%02h cnt=%0d, expected all 0",
               in_ready, stuff, out_valid, done, err, out_data, byte_cnt);
    end
    rst = 1'b1;
    #1;
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_basic();
    outQ.delete();
    applyStimulus(1'b1, 8'h12, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h56, 1'b0, 1'b1);
    tick();
    compared++;
    if ({out_valid, out_data, done} !== {1'b1, 8'h56, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL basic_last_byte: got vld=%b data=%02h done=%b expected 1 56 0",
               out_valid, out_data, done);
    end
    tick();
    compared++;
    if ({done, out_valid, byte_cnt} !== {1'b1, 1'b0, 16'd3}) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got done=%b vld=%b cnt=%0d expected 1 0 3",
               done, out_valid, byte_cnt);
    end
    compared++;
    if (outQ.size() != 3 || outQ[0] !== 8'h12 || outQ[1] !== 8'h34 || outQ[2] !== 8'h56) begin
      mismatched++;
      $display("[TB] FAIL basic_sequence: got %s expected 12 34 56", qStr());
    end
    tick();
    compared++;
    if ({done, byte_cnt} !== {1'b0, 16'd3}) begin
      mismatched++;
      $display("[TB] FAIL basic_done_pulse: got done=%b cnt=%0d expected 0 3", done, byte_cnt);
    end
  endtask

  task automatic test_carry();
    outQ.delete();
    applyStimulus(1'b1, 8'h7F, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h00, 1'b1, 1'b0);
    compared++;
    if ({out_valid, out_data, err} !== {1'b1, 8'h80, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL carry_fold: got vld=%b data=%02h err=%b expected 1 80 0",
               out_valid, out_data, err);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    waitDone();
    compared++;
    if (done !== 1'b1 || byte_cnt !== 16'd2 || outQ.size() != 2 ||
        outQ[0] !== 8'h80 || outQ[1] !== 8'h00) begin
      mismatched++;
      $display("[TB] FAIL carry_codeword: got done=%b cnt=%0d seq=%s expected 1 2 80 00",
               done, byte_cnt, qStr());
    end
    tick();
  endtask

  task automatic test_stuff();
    outQ.delete();
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b0);
    compared++;
    if (stuff !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL stuff_flag: got %b expected 1", stuff);
    end
    applyStimulus(1'b1, 8'h11, 1'b1, 1'b0);
    compared++;
    if ({out_data, err, stuff} !== {8'hFF, 1'b1, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL stuff_carry_err: got data=%02h err=%b stuff=%b expected ff 1 0",
               out_data, err, stuff);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    waitDone();
    compared++;
    if (done !== 1'b1 || err !== 1'b1 || outQ.size() != 2 ||
        outQ[0] !== 8'hFF || outQ[1] !== 8'h11) begin
      mismatched++;
      $display("[TB] FAIL stuff_codeword: got done=%b err=%b seq=%s expected 1 1 ff 11",
               done, err, qStr());
    end
    tick();
  endtask

  task automatic test_trailing_ff();
    outQ.delete();
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0, 1'b1);
    waitDone();
`ifdef MQ_TRAIL_FF_DROP_EN
    compared++;
    if (done !== 1'b1 || byte_cnt !== 16'd1 || outQ.size() != 1 || outQ[0] !== 8'hAA) begin
      mismatched++;
      $display("[TB] FAIL trailing_ff_drop: got done=%b cnt=%0d seq=%s expected 1 1 aa",
               done, byte_cnt, qStr());
    end
`else
    compared++;
    if (done !== 1'b1 || byte_cnt !== 16'd2 || outQ.size() != 2 ||
        outQ[0] !== 8'hAA || outQ[1] !== 8'hFF) begin
      mismatched++;
      $display("[TB] FAIL trailing_ff_keep: got done=%b cnt=%0d seq=%s expected 1 2 aa ff",
               done, byte_cnt, qStr());
    end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    outQ.delete();
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    out_ready = 1'b0;
    byte_vld  = 1'b1;
    byte_in   = 8'h23;
    #1;
    compared++;
    if (in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL stall_ready: got %b expected 0", in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if ({out_valid, out_data, in_ready} !== {1'b1, 8'h21, 1'b0}) begin
        mismatched++;
        $display("[TB] FAIL stall_hold_%0d: got vld=%b data=%02h rdy=%b expected 1 21 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    out_ready = 1'b1;
    applyStimulus(1'b1, 8'h23, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    waitDone();
    compared++;
    if (done !== 1'b1 || byte_cnt !== 16'd3 || outQ.size() != 3 ||
        outQ[0] !== 8'h21 || outQ[1] !== 8'h22 || outQ[2] !== 8'h23) begin
      mismatched++;
      $display("[TB] FAIL stall_no_loss: got done=%b cnt=%0d seq=%s expected 1 3 21 22 23",
               done, byte_cnt, qStr());
    end
    tick();
  endtask

  task automatic test_reset_in_flush();
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    out_ready = 1'b0;
    tick();
    compared++;
    if ({out_valid, out_data, in_ready} !== {1'b1, 8'h31, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL flush_pending: got vld=%b data=%02h rdy=%b expected 1 31 0",
               out_valid, out_data, in_ready);
    end
    rst = 1'b0;
    tick();
    compared++;
    if ({in_ready, stuff, out_valid, done, err, out_data, byte_cnt} !== 29'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_in_flush: got rdy=%b stuff=%b vld=%b done=%b err=%b data=%02h cnt=%0d, expected all 0",
               in_ready, stuff, out_valid, done, err, out_data, byte_cnt);
    end
    rst       = 1'b1;
    out_ready = 1'b1;
    outQ.delete();
    tick();
    tick();
    tick();
    compared++;
    if (outQ.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_discard: got seq=%s vld=%b rdy=%b expected empty 0 1",
               qStr(), out_valid, in_ready);
    end
  endtask

  task automatic test_idle_flush();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    compared++;
    if ({done, byte_cnt} !== {1'b1, 16'd0}) begin
      mismatched++;
      $display("[TB] FAIL idle_flush_done: got done=%b cnt=%0d expected 1 0", done, byte_cnt);
    end
    tick();
    compared++;
    if ({done, in_ready} !== {1'b0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL idle_flush_return: got done=%b rdy=%b expected 0 1", done, in_ready);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b0;
    byte_vld   = 1'b0;
    byte_in    = 8'h00;
    carry_in   = 1'b0;
    flush      = 1'b0;
    out_ready  = 1'b1;
    test_reset();
    test_basic();
    test_carry();
    test_stuff();
    test_trailing_ff();
    test_backpressure();
    test_reset_in_flush();
    test_idle_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
